hyperbus_read_burst_ctrl: RTL and testbench

Sequencer for the HyperBus read-capture path in the RWDS clock domain. It counts RWDS edges and discards the priming edge and a programmable number of leading words. It then qualifies exactly `burst_len_i` words into the read CDC FIFO, tags the final word, and flags overflow and burst completion. It sits between the per-bit DDR input cells and the source side of the read CDC FIFO, and replaces the free-running "valid after first edge" flag.

---
 rtl/hyperbus_read_burst_ctrl.sv | 122 ++++++++++++
 tb/tb_hyperbus_read_burst_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/hyperbus_read_burst_ctrl.sv
// HyperBus read-capture sequencer in the RWDS domain: drops the priming edge and leading
// words, then qualifies a fixed-length burst into the read CDC FIFO. Option: HYPERBUS_RD_EXTRA_EDGE_CNT_EN.
module hyperbus_read_burst_ctrl #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned SKIP_W = 4
) (
  input  logic              clk_rwds,
  input  logic              resetReadModule,
  input  logic [CNT_W-1:0]  burst_len_i,
  input  logic [SKIP_W-1:0] skip_i,
  input  logic [15:0]       ddr_data_i,
  input  logic              fifo_ready_i,
  output logic              fifo_valid_o,
  output logic [16:0]       fifo_data_o,
  output logic              done_o,
  output logic              overflow_o,
  output logic [CNT_W-1:0]  word_cnt_o,
  output logic [7:0]        extra_edges_o
);

  typedef enum logic [1:0] {
    PRIME  = 2'd0,
    SKIP   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SKIP_W-1:0] r_skip_cnt;
  logic [SKIP_W-1:0] w_skip_cnt_nxt;
  logic [CNT_W-1:0]  r_word_cnt;
  logic [CNT_W-1:0]  w_word_cnt_nxt;
  logic              r_overflow;
  logic              w_overflow_nxt;

  logic w_skip_zero;
  logic w_len_zero;
  logic w_skip_last;
  logic w_word_last;
  logic w_streaming;

  assign w_skip_zero = (skip_i == '0);
  assign w_len_zero  = (burst_len_i == '0);
  assign w_skip_last = (r_skip_cnt == (skip_i - SKIP_W'(1)));
  assign w_word_last = (r_word_cnt == (burst_len_i - CNT_W'(1)));
  assign w_streaming = (r_state == STREAM);

  // State and counter registers; an asserted reset kills the burst instantly.
  always_ff @(posedge clk_rwds or posedge resetReadModule) begin
    if (resetReadModule) begin
      r_state    <= PRIME;
      r_skip_cnt <= '0;
      r_word_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_skip_cnt <= w_skip_cnt_nxt;
      r_word_cnt <= w_word_cnt_nxt;
      r_overflow <= w_overflow_nxt;
    end
  end

  // Next-state logic; every counter leaves its state at its terminal value, so none can wrap.
  always_comb begin
    w_state_nxt    = r_state;
    w_skip_cnt_nxt = r_skip_cnt;
    w_word_cnt_nxt = r_word_cnt;
    w_overflow_nxt = r_overflow;
    case (r_state)
      PRIME: begin
        if (!w_skip_zero)     w_state_nxt = SKIP;
        else if (!w_len_zero) w_state_nxt = STREAM;
        else                  w_state_nxt = DONE;
      end
      SKIP: begin
        if (w_skip_last) begin
          w_skip_cnt_nxt = '0;
          w_state_nxt    = w_len_zero ? DONE : STREAM;
        end else begin
          w_skip_cnt_nxt = r_skip_cnt + SKIP_W'(1);
        end
      end
      STREAM: begin
        // A word refused by the FIFO is still counted to stay aligned with the bus.
        w_word_cnt_nxt = r_word_cnt + CNT_W'(1);
        if (!fifo_ready_i) w_overflow_nxt = 1'b1;
        if (w_word_last)   w_state_nxt    = DONE;
      end
      DONE: begin
        w_state_nxt = DONE;
      end
      default: begin
        w_state_nxt = PRIME;
      end
    endcase
  end

  assign fifo_valid_o = w_streaming;
  assign fifo_data_o  = {w_streaming & w_word_last, ddr_data_i};
  assign done_o       = (r_state == DONE);
  assign overflow_o   = r_overflow;
  assign word_cnt_o   = r_word_cnt;

`ifdef HYPERBUS_RD_EXTRA_EDGE_CNT_EN
  logic [7:0] r_extra_edges;

  // Saturating count of edges arriving after the burst completed.
  always_ff @(posedge clk_rwds or posedge resetReadModule) begin
    if (resetReadModule) begin
      r_extra_edges <= 8'd0;
    end else if ((r_state == DONE) && (r_extra_edges != 8'hFF)) begin
      r_extra_edges <= r_extra_edges + 8'd1;
    end
  end

  assign extra_edges_o = r_extra_edges;
`else
  assign extra_edges_o = 8'd0;
`endif

endmodule

// File: tb/tb_hyperbus_read_burst_ctrl.sv
// Self-checking bench for hyperbus_read_burst_ctrl: directed and randomized bursts
// checked against an edge-number model of the read-burst timing.
module tb_hyperbus_read_burst_ctrl;

  logic        clk_rwds        = 1'b0;
  logic        resetReadModule = 1'b1;
  logic [15:0] burst_len_i     = 16'd0;
  logic [3:0]  skip_i          = 4'd0;
  logic [15:0] ddr_data_i      = 16'd0;
  logic        fifo_ready_i    = 1'b1;
  logic        fifo_valid_o;
  logic [16:0] fifo_data_o;
  logic        done_o;
  logic        overflow_o;
  logic [15:0] word_cnt_o;
  logic [7:0]  extra_edges_o;

  int checks = 0;
  int errors = 0;

  hyperbus_read_burst_ctrl #(.CNT_W(16), .SKIP_W(4)) dut (
    .clk_rwds        (clk_rwds),
    .resetReadModule (resetReadModule),
    .burst_len_i     (burst_len_i),
    .skip_i          (skip_i),
    .ddr_data_i      (ddr_data_i),
    .fifo_ready_i    (fifo_ready_i),
    .fifo_valid_o    (fifo_valid_o),
    .fifo_data_o     (fifo_data_o),
    .done_o          (done_o),
    .overflow_o      (overflow_o),
    .word_cnt_o      (word_cnt_o),
    .extra_edges_o   (extra_edges_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_valid"},    32'(fifo_valid_o),      32'd0);
    chk({tag, "_last"},     32'(fifo_data_o[16]),   32'd0);
    chk({tag, "_data"},     32'(fifo_data_o[15:0]), 32'(ddr_data_i));
    chk({tag, "_done"},     32'(done_o),            32'd0);
    chk({tag, "_overflow"}, 32'(overflow_o),        32'd0);
    chk({tag, "_wordcnt"},  32'(word_cnt_o),        32'd0);
    chk({tag, "_extra"},    32'(extra_edges_o),     32'd0);
  endtask

  // Edges seen after completion, as the optional counter should report them.
  function automatic int exp_extra(input int m, input int s, input int l);
    int e;
`ifdef HYPERBUS_RD_EXTRA_EDGE_CNT_EN
    e = m - (1 + s + l);
    if (e < 0)   e = 0;
    if (e > 255) e = 255;
`else
    e = 0;
`endif
    return e;
  endfunction

  // rdy_mode: 0 always ready, 1 not ready on edge rdy_low only, 2 random.
  // abort_after > 0 asserts reset in the gap after that many edges.
  task automatic run_burst(input string tag, input int s, input int l, input int n_edges,
                           input int rdy_mode, input int rdy_low, input int abort_after);
    int  m;
    int  wc;
    int  lasts;
    bit  ev, el, ov;
    ov    = 1'b0;
    lasts = 0;
    skip_i          = 4'(s);
    burst_len_i     = 16'(l);
    fifo_ready_i    = 1'b1;
    ddr_data_i      = 16'($urandom);
    resetReadModule = 1'b1;
    #2;
    check_reset({tag, "_rst"});
    resetReadModule = 1'b0;
    #2;
    for (int n = 1; n <= n_edges; n++) begin
      m = n - 1;
      ddr_data_i = 16'($urandom);
      case (rdy_mode)
        1:       fifo_ready_i = (n != rdy_low);
        2:       fifo_ready_i = ($urandom_range(0, 3) != 0);
        default: fifo_ready_i = 1'b1;
      endcase
      #1;
      // Outputs seen by edge n reflect the m = n-1 edges already taken.
      ev = (m >= 1 + s) && (m < 1 + s + l);
      el = ev && (m == s + l);
      chk({tag, "_valid"}, 32'(fifo_valid_o),      32'(ev));
      chk({tag, "_last"},  32'(fifo_data_o[16]),   32'(el));
      chk({tag, "_data"},  32'(fifo_data_o[15:0]), 32'(ddr_data_i));
      if (fifo_valid_o && fifo_data_o[16]) lasts++;
      if (ev && !fifo_ready_i) ov = 1'b1;
      #2;
      clk_rwds = 1'b1;
      #2;
      m  = n;
      wc = m - 1 - s;
      if (wc < 0) wc = 0;
      if (wc > l) wc = l;
      chk({tag, "_done"},     32'(done_o),        32'(m >= 1 + s + l));
      chk({tag, "_wordcnt"},  32'(word_cnt_o),    32'(wc));
      chk({tag, "_overflow"}, 32'(overflow_o),    32'(ov));
      chk({tag, "_extra"},    32'(extra_edges_o), 32'(exp_extra(m, s, l)));
      #3;
      clk_rwds = 1'b0;
      #2;
      if (n == abort_after) begin
        resetReadModule = 1'b1;
        #1;
        check_reset({tag, "_abort"});
        return;
      end
    end
    chk({tag, "_lastcount"}, 32'(lasts), 32'((l != 0) ? 1 : 0));
  endtask

  initial begin
    int s, l, n;
    #3;
    check_reset("por");
    run_burst("s0l4",    0, 4,  6,  0, 0, 0);
    run_burst("s2l3",    2, 3,  8,  0, 0, 0);
    run_burst("l0",      0, 0,  6,  0, 0, 0);
    run_burst("l0sat",   0, 0,  300, 0, 0, 0);
    run_burst("s5l0",    5, 0,  9,  0, 0, 0);
    run_burst("ovf",     0, 8,  11, 1, 4, 0);
    run_burst("s15l1",   15, 1, 19, 0, 0, 0);
    run_burst("abort",   0, 8,  10, 0, 0, 3);
    run_burst("after",   0, 2,  4,  0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      s = int'($urandom_range(0, 15));
      l = int'($urandom_range(0, 20));
      n = 1 + s + l + int'($urandom_range(0, 4));
      run_burst("rand", s, l, n, 2, 0, 0);
    end
    run_burst("max", 0, 16'hFFFF, 32'h10001, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
